mem_stage: RTL and testbench

- Memory-access stage directly downstream of the ALU in the MIPS datapath.
- Takes the ALU result with opcode, store data and destination register, and performs word load/store over a request/ready data-memory bus.
- Passes non-memory results through to writeback; stalls upstream with in_ready while a bus transaction is outstanding.
- Flags misaligned addresses and bus timeouts.

---
 rtl/mem_stage.sv | 98 +++++++++
 tb/tb_mem_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage doing word load/store over a req/ready bus
module mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       store_data,
  input  logic [4:0]        dest_reg,
  input  logic              reg_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic              addr_err,
  output logic              bus_err
);
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0] wdata_r, data_r;
  logic [4:0] reg_r;
  logic is_sw_r, we_r, aerr_r, berr_r;
  logic accept, is_mem, misal, timed_out;
  assign accept    = in_valid & in_ready;
  assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
  assign misal     = |alu_out[1:0];
  assign timed_out = (TIMEOUT != 0) && (cnt == TMAX) && !mem_ready;
  // next state: aligned memory ops go to the bus, everything else straight to writeback
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (accept ? ((is_mem && !misal) ? BUS : RESP) : IDLE) :
          state == BUS  ? ((mem_ready || timed_out) ? RESP : BUS) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  // capture the instruction at accept, then the bus outcome while in BUS
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      data_r  <= '0;
      reg_r   <= '0;
      is_sw_r <= 1'b0;
      we_r    <= 1'b0;
      aerr_r  <= 1'b0;
      berr_r  <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      addr_r  <= alu_out[ADDR_W-1:0];
      wdata_r <= opcode == OP_SW ? store_data : 32'h0;
      data_r  <= alu_out;
      reg_r   <= dest_reg;
      is_sw_r <= opcode == OP_SW;
      we_r    <= !is_mem && reg_write;
      aerr_r  <= is_mem && misal;
      berr_r  <= 1'b0;
    end else if (state == BUS) begin
      if (mem_ready) begin
        data_r <= is_sw_r ? 32'h0 : mem_rdata;
        we_r   <= !is_sw_r;
      end else if (timed_out) begin
        data_r <= 32'h0;
        berr_r <= 1'b1;
      end else cnt <= cnt + CW'(1);
    end
  end
  assign in_ready  = state == IDLE;
  assign mem_req   = state == BUS;
  assign mem_we    = mem_req & is_sw_r;
  assign mem_addr  = mem_req ? addr_r : '0;
  assign mem_wdata = mem_req ? wdata_r : 32'h0;
  assign wb_valid  = state == RESP;
  assign wb_we     = wb_valid & we_r;
  assign wb_reg    = wb_valid ? reg_r : 5'h0;
  assign wb_data   = wb_valid ? data_r : 32'h0;
  assign addr_err  = wb_valid & aerr_r;
  assign bus_err   = wb_valid & berr_r;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors plus bus-latency/timeout/reset sequences for mem_stage
module tb_mem_stage;
  logic clk = 0, reset = 1, in_valid = 0, in_ready;
  logic [5:0] opcode = 0;
  logic [31:0] alu_out = 0, store_data = 0, mem_rdata = 0;
  logic [4:0] dest_reg = 0;
  logic reg_write = 0, mem_ready = 0;
  logic mem_req, mem_we, wb_valid, wb_we, addr_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [4:0] wb_reg;
  int total = 0, bad = 0;

  mem_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_out(alu_out), .store_data(store_data),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .addr_err(addr_err), .bus_err(bus_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        rw;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_aerr;
  } vec_t;

  vec_t vecs[6];

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] d, input logic rw);
    in_valid = 1; opcode = op; alu_out = a; store_data = sd; dest_reg = d; reg_write = rw;
    tick();
    in_valid = 0; opcode = 6'h3F; alu_out = 32'h5555_5555; store_data = 32'hAAAA_AAAA;
    dest_reg = 5'h1F; reg_write = 1;
  endtask

  // aligned LW/SW; ready raised after `waits` low cycles (negative = never)
  task automatic bus_op(input string nm, input logic sw, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input logic e_berr);
    int n;
    int e_n;
    n = 0;
    e_n = e_berr ? 5 : waits + 1;
    issue(sw ? 6'h2B : 6'h23, a, sd, 5'd7, 1'b0);
    for (int k = 0; k < 20 && !wb_valid; k++) begin
      chk({nm, " mem_req"}, {31'b0, mem_req}, 1);
      chk({nm, " mem_addr"}, mem_addr, a);
      chk({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, sw});
      chk({nm, " mem_wdata"}, mem_wdata, sw ? sd : 32'h0);
      chk({nm, " in_ready"}, {31'b0, in_ready}, 0);
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rd : 32'hBAD0_0000 + k;
      tick();
      mem_ready = 0;
      n++;
    end
    chk({nm, " req_cycles"}, n, e_n);
    chk({nm, " wb_valid"}, {31'b0, wb_valid}, 1);
    chk({nm, " mem_req_off"}, {31'b0, mem_req}, 0);
    chk({nm, " wb_we"}, {31'b0, wb_we}, {31'b0, !sw && !e_berr});
    chk({nm, " bus_err"}, {31'b0, bus_err}, {31'b0, e_berr});
    chk({nm, " addr_err"}, {31'b0, addr_err}, 0);
    if (!sw && !e_berr) begin
      chk({nm, " wb_data"}, wb_data, rd);
      chk({nm, " wb_reg"}, {27'b0, wb_reg}, 7);
    end
    if (sw) chk({nm, " wb_data_sw"}, wb_data, 0);
    tick();
    chk({nm, " in_ready_after"}, {31'b0, in_ready}, 1);
    chk({nm, " wb_valid_after"}, {31'b0, wb_valid}, 0);
  endtask

  initial begin
    vecs[0] = '{6'h00, 32'h0000_0042, 5'd5,  1'b1, 32'h0000_0042, 1'b1, 1'b0};
    vecs[1] = '{6'h08, 32'h1234_5677, 5'd9,  1'b0, 32'h1234_5677, 1'b0, 1'b0};
    vecs[2] = '{6'h0F, 32'hFFFF_0003, 5'd31, 1'b1, 32'hFFFF_0003, 1'b1, 1'b0};
    vecs[3] = '{6'h23, 32'h0000_0102, 5'd3,  1'b1, 32'h0000_0102, 1'b0, 1'b1};
    vecs[4] = '{6'h2B, 32'h0000_0203, 5'd4,  1'b1, 32'h0000_0203, 1'b0, 1'b1};
    vecs[5] = '{6'h23, 32'h8000_0001, 5'd6,  1'b0, 32'h8000_0001, 1'b0, 1'b1};

    tick(); tick();
    reset = 0;
    chk("rst in_ready", {31'b0, in_ready}, 1);
    chk("rst mem_req", {31'b0, mem_req}, 0);
    chk("rst wb_valid", {31'b0, wb_valid}, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst addr/bus_err", {30'b0, addr_err, bus_err}, 0);

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 1);
      issue(vecs[i].op, vecs[i].alu, 32'hCAFE_F00D, vecs[i].dst, vecs[i].rw);
      chk($sformatf("v%0d wb_valid", i), {31'b0, wb_valid}, 1);
      chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("v%0d wb_we", i), {31'b0, wb_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d wb_reg", i), {27'b0, wb_reg}, {27'b0, vecs[i].dst});
      chk($sformatf("v%0d addr_err", i), {31'b0, addr_err}, {31'b0, vecs[i].e_aerr});
      chk($sformatf("v%0d bus_err", i), {31'b0, bus_err}, 0);
      chk($sformatf("v%0d mem_req", i), {31'b0, mem_req}, 0);
      chk($sformatf("v%0d in_ready_resp", i), {31'b0, in_ready}, 0);
      tick();
      chk($sformatf("v%0d wb_valid_after", i), {31'b0, wb_valid}, 0);
      chk($sformatf("v%0d mem_req_after", i), {31'b0, mem_req}, 0);
    end

    bus_op("lw0", 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    bus_op("sw3", 1'b1, 32'h0000_0200, 32'hCAFE_0001, 32'h0, 3, 1'b0);
    bus_op("lw_to", 1'b0, 32'h0000_0300, 32'h0, 32'h0, -1, 1'b1);
    bus_op("lw_race", 1'b0, 32'h0000_0304, 32'h0, 32'h1357_9BDF, 4, 1'b0);

    issue(6'h2B, 32'h0000_0400, 32'h0BAD_CAFE, 5'd2, 1'b0);
    chk("rst_mid bus1", {31'b0, mem_req}, 1);
    tick();
    chk("rst_mid bus2", {31'b0, mem_req}, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid mem_req", {31'b0, mem_req}, 0);
    chk("rst_mid wb_valid", {31'b0, wb_valid}, 0);
    tick();
    chk("rst_mid in_ready", {31'b0, in_ready}, 1);
    chk("rst_mid no_wb", {31'b0, wb_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
